// File: rtl/tag_free_list.sv
// rtl/tag_free_list.sv - free-tag bitmap with lowest-index allocator; optional checker via TAG_FREE_LIST_DBLFREE_CHK_EN
module tag_free_list #(
   parameter int N        = 32,
   parameter int NUM_FREE = 2,
   parameter int RESV     = 0,
   localparam int W       = (N > 1) ? $clog2(N) : 1,
   localparam int CW      = $clog2(N + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alloc_en,
   output logic                  alloc_valid,
   output logic [W-1:0]          alloc_idx,
   input  logic [NUM_FREE-1:0]   free_en,
   input  logic [NUM_FREE*W-1:0] free_idx,
   output logic [CW-1:0]         free_count,
   output logic                  dbl_free_err
);

   logic [N-1:0]  fl_q, fl_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  alloc_oh;
   logic [N-1:0]  free_oh;
   logic [N-1:0]  port_oh [NUM_FREE];
   logic          alloc_fire;

   // Lowest set bit of the registered bitmap; defaults to 0 when nothing is free.
   always_comb begin
      alloc_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (fl_q[i]) alloc_idx = W'(i);
      end
   end

   assign alloc_valid = |fl_q;
   assign alloc_fire  = alloc_en && alloc_valid;

   // Decode each free port to one-hot; out-of-range indices decode to all zeros.
   always_comb begin
      for (int k = 0; k < NUM_FREE; k++) begin
         port_oh[k] = '0;
         for (int i = 0; i < N; i++) begin
            if (free_en[k] && (free_idx[k*W +: W] == W'(i))) port_oh[k][i] = 1'b1;
         end
      end
   end

   // Merge frees and the granted allocation into the next bitmap and its popcount.
   always_comb begin
      alloc_oh = '0;
      free_oh  = '0;
      cnt_d    = '0;
      for (int i = 0; i < N; i++) begin
         if (alloc_fire && (alloc_idx == W'(i))) alloc_oh[i] = 1'b1;
      end
      for (int k = 0; k < NUM_FREE; k++) begin
         free_oh = free_oh | port_oh[k];
      end
      // Free wins over alloc on the same bit.
      fl_d = (fl_q & ~alloc_oh) | free_oh;
      for (int i = 0; i < N; i++) begin
         cnt_d = cnt_d + CW'(fl_d[i]);
      end
   end

   // Bitmap and count registers; reset holds tags below RESV.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N; i++) fl_q[i] <= (i >= RESV);
         cnt_q <= CW'(N - RESV);
      end else begin
         fl_q  <= fl_d;
         cnt_q <= cnt_d;
      end
   end

   assign free_count = cnt_q;

`ifdef TAG_FREE_LIST_DBLFREE_CHK_EN
   logic err_q, err_d;

   // Flag a free of an already-free tag (unless it is the tag leaving this cycle) or a same-cycle duplicate.
   always_comb begin
      err_d = err_q;
      for (int k = 0; k < NUM_FREE; k++) begin
         if (|(port_oh[k] & fl_q & ~alloc_oh)) err_d = 1'b1;
         for (int j = 0; j < k; j++) begin
            if (|(port_oh[k] & port_oh[j])) err_d = 1'b1;
         end
      end
   end

   // Sticky error register, cleared only by reset.
   always_ff @(posedge clock) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign dbl_free_err = err_q;
`else
   assign dbl_free_err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// tb/tb_tag_free_list.sv - directed bench for tag_free_list (N=8, RESV=0 and RESV=3)
module tb_tag_free_list;

   logic       clock = 1'b0;
   logic       reset;
   logic       alloc_en;
   logic [1:0] free_en;
   logic [5:0] free_idx;

   logic       v0, v3, e0, e3;
   logic [2:0] i0, i3;
   logic [3:0] c0, c3;

   int passed = 0;
   int total  = 0;

`ifdef TAG_FREE_LIST_DBLFREE_CHK_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   tag_free_list #(.N(8), .NUM_FREE(2), .RESV(0)) u0 (
      .clock(clock), .reset(reset), .alloc_en(alloc_en),
      .alloc_valid(v0), .alloc_idx(i0), .free_en(free_en),
      .free_idx(free_idx), .free_count(c0), .dbl_free_err(e0)
   );

   tag_free_list #(.N(8), .NUM_FREE(2), .RESV(3)) u3 (
      .clock(clock), .reset(reset), .alloc_en(alloc_en),
      .alloc_valid(v3), .alloc_idx(i3), .free_en(free_en),
      .free_idx(free_idx), .free_count(c3), .dbl_free_err(e3)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_state(input string name, input logic v, input logic [2:0] idx,
                            input logic [3:0] cnt);
      total++;
      if (v0 !== v || i0 !== idx || c0 !== cnt)
         $display("FAIL %s: got valid=%b idx=%0d count=%0d want valid=%b idx=%0d count=%0d",
                  name, v0, i0, c0, v, idx, cnt);
      else passed++;
   endtask

   task automatic chk_err(input string name, input logic exp);
      total++;
      if (e0 !== exp) $display("FAIL %s: got dbl_free_err=%b want %b", name, e0, exp);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b1; alloc_en = 1'b0; free_en = 2'b00; free_idx = '0;
      step();
      reset = 1'b0;
      chk_state("reset_resv0", 1'b1, 3'd0, 4'd8);
      chk_err("reset_err", 1'b0);
      total++;
      if (v3 !== 1'b1 || i3 !== 3'd3 || c3 !== 4'd5)
         $display("FAIL reset_resv3: got valid=%b idx=%0d count=%0d want valid=1 idx=3 count=5",
                  v3, i3, c3);
      else passed++;
   endtask

   task automatic test_alloc_drain();
      alloc_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++;
         if (i0 !== 3'(i) || v0 !== 1'b1)
            $display("FAIL drain_idx%0d: got idx=%0d valid=%b want idx=%0d valid=1", i, i0, v0, i);
         else passed++;
         step();
         if (i == 0) chk_state("drain_count_after_first", 1'b1, 3'd1, 4'd7);
      end
      chk_state("drain_empty", 1'b0, 3'd0, 4'd0);
      step();
      chk_state("drain_ninth_alloc_ignored", 1'b0, 3'd0, 4'd0);
      alloc_en = 1'b0;
   endtask

   task automatic test_free_two();
      free_en = 2'b11; free_idx = {3'd2, 3'd5};
      #1;
      total++;
      if (v0 !== 1'b0) $display("FAIL no_bypass: got valid=%b want 0", v0);
      else passed++;
      step();
      free_en = 2'b00;
      chk_state("free_two", 1'b1, 3'd2, 4'd2);
      alloc_en = 1'b1;
      step();
      alloc_en = 1'b0;
      chk_state("free_two_then_alloc", 1'b1, 3'd5, 4'd1);
   endtask

   task automatic test_alloc_and_free();
      free_en = 2'b01; free_idx = {3'd0, 3'd2};
      step();
      chk_state("refree_2", 1'b1, 3'd2, 4'd2);
      alloc_en = 1'b1; free_en = 2'b01; free_idx = {3'd0, 3'd6};
      step();
      chk_state("alloc_plus_free6", 1'b1, 3'd5, 4'd2);
      free_idx = {3'd0, 3'd5};
      step();
      alloc_en = 1'b0; free_en = 2'b00;
      chk_state("free_wins_over_alloc", 1'b1, 3'd5, 4'd2);
      chk_err("free_wins_no_err", 1'b0);
   endtask

   task automatic test_dup_and_dbl();
      free_en = 2'b11; free_idx = {3'd3, 3'd3};
      step();
      free_en = 2'b00;
      chk_state("dup_idempotent", 1'b1, 3'd3, 4'd3);
      chk_err("dup_err", ERR_EXP);
      free_en = 2'b01; free_idx = {3'd0, 3'd3};
      step();
      free_en = 2'b00;
      chk_state("dbl_free_state", 1'b1, 3'd3, 4'd3);
      chk_err("dbl_free_err", ERR_EXP);
      step();
      step();
      chk_err("dbl_free_sticky", ERR_EXP);
   endtask

   task automatic test_full();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_err("err_cleared_by_reset", 1'b0);
      free_en = 2'b11; free_idx = {3'd7, 3'd0};
      step();
      free_en = 2'b00;
      chk_state("full_free_unchanged", 1'b1, 3'd0, 4'd8);
   endtask

   task automatic test_mid_reset();
      alloc_en = 1'b1;
      step();
      chk_state("pre_reset_alloc", 1'b1, 3'd1, 4'd7);
      reset = 1'b1; free_en = 2'b11; free_idx = {3'd1, 3'd0};
      step();
      reset = 1'b0; alloc_en = 1'b0; free_en = 2'b00;
      chk_state("mid_reset", 1'b1, 3'd0, 4'd8);
      chk_err("mid_reset_err", 1'b0);
   endtask

   initial begin
      test_reset();
      test_alloc_drain();
      test_free_two();
      test_alloc_and_free();
      test_dup_and_dbl();
      test_full();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
